vga_sincronizacion: RTL and testbench



---
 rtl/vga_sincronizacion_if.sv | 38 +++
 rtl/vga_sincronizacion.sv | 119 +++++++++++
 tb/tb_vga_sincronizacion.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/vga_sincronizacion_if.sv
// vga_sincronizacion_if
// Bundles the VGA timing outputs that the sync generator drives towards the
// painter and the monitor pins.
//   master : driven by vga_sincronizacion
//   slave  : consumed by the painter / monitor connector
// Signals:
//   X, Y         current pixel coordinates (10 bits each)
//   HS, VS       active-low sync pulses
//   VIDEO_ON     (X,Y) lies in the visible area
//   PIXEL_TICK   one-CLK strobe per pixel period
//   FRAME_START  one-CLK strobe when the counters land on (0,0)
//   FRAME_CNT    8-bit frame counter, only with VGA_FRAME_COUNT_EN defined
interface vga_sincronizacion_if;
    logic [9:0] X;
    logic [9:0] Y;
    logic       HS;
    logic       VS;
    logic       VIDEO_ON;
    logic       PIXEL_TICK;
    logic       FRAME_START;
`ifdef VGA_FRAME_COUNT_EN
    logic [7:0] FRAME_CNT;
`endif

    modport master (
        output X, Y, HS, VS, VIDEO_ON, PIXEL_TICK, FRAME_START
`ifdef VGA_FRAME_COUNT_EN
        , output FRAME_CNT
`endif
    );

    modport slave (
        input X, Y, HS, VS, VIDEO_ON, PIXEL_TICK, FRAME_START
`ifdef VGA_FRAME_COUNT_EN
        , input FRAME_CNT
`endif
    );
endinterface

// File: rtl/vga_sincronizacion.sv
// vga_sincronizacion
// 640x480 @ 60 Hz VGA timing generator. A clock divider produces the pixel
// tick; cascaded horizontal/vertical counters produce X/Y, and HS, VS and
// VIDEO_ON are registered from the next-state counter values so they line up
// with X/Y exactly.
// Ports:
//   CLK      system clock (only clock)
//   RESET_N  asynchronous active-low reset
//   vga      timing outputs (vga_sincronizacion_if.master)
// Optional feature: define VGA_FRAME_COUNT_EN to compile in the 8-bit
// FRAME_CNT register, incremented on every frame start.
module vga_sincronizacion #(
    parameter int unsigned DIV    = 4,
    parameter int unsigned H_VIS  = 640,
    parameter int unsigned H_FP   = 16,
    parameter int unsigned H_SYNC = 96,
    parameter int unsigned H_BP   = 48,
    parameter int unsigned V_VIS  = 480,
    parameter int unsigned V_FP   = 10,
    parameter int unsigned V_SYNC = 2,
    parameter int unsigned V_BP   = 33
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    vga_sincronizacion_if.master vga
);
    localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int unsigned DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS_W  = 10'(H_VIS);
    localparam logic [9:0] V_VIS_W  = 10'(V_VIS);
    localparam logic [9:0] HS_START = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_VIS + V_FP + V_SYNC);

    logic [DIV_W-1:0] divCnt, divNext;
    logic [9:0]       xCnt, xNext;
    logic [9:0]       yCnt, yNext;
    logic             hsReg, hsNext;
    logic             vsReg, vsNext;
    logic             videoReg, videoNext;
    logic             frameStartReg, frameStartNext;
    logic             pixelTick;

    // Gating with RESET_N keeps the tick low during reset even when DIV = 1,
    // where the divider always sits at its last value.
    assign pixelTick = RESET_N && (divCnt == DIV_LAST);

    always_comb begin
        divNext        = pixelTick ? '0 : divCnt + DIV_W'(1);
        xNext          = xCnt;
        yNext          = yCnt;
        frameStartNext = 1'b0;
        if (pixelTick) begin
            if (xCnt == H_LAST) begin
                xNext = '0;
                if (yCnt == V_LAST) begin
                    yNext          = '0;
                    frameStartNext = 1'b1;
                end else begin
                    yNext = yCnt + 10'd1;
                end
            end else begin
                xNext = xCnt + 10'd1;
            end
        end
        // Decoded from next-state values so the registered flags match X/Y.
        hsNext    = !((xNext >= HS_START) && (xNext < HS_END));
        vsNext    = !((yNext >= VS_START) && (yNext < VS_END));
        videoNext = (xNext < H_VIS_W) && (yNext < V_VIS_W);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            divCnt        <= '0;
            xCnt          <= '0;
            yCnt          <= '0;
            hsReg         <= 1'b1;
            vsReg         <= 1'b1;
            videoReg      <= 1'b1;
            frameStartReg <= 1'b0;
        end else begin
            divCnt        <= divNext;
            xCnt          <= xNext;
            yCnt          <= yNext;
            hsReg         <= hsNext;
            vsReg         <= vsNext;
            videoReg      <= videoNext;
            frameStartReg <= frameStartNext;
        end
    end

`ifdef VGA_FRAME_COUNT_EN
    logic [7:0] frameCnt;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            frameCnt <= '0;
        end else if (frameStartNext) begin
            frameCnt <= frameCnt + 8'd1;
        end
    end

    assign vga.FRAME_CNT = frameCnt;
`endif

    assign vga.X           = xCnt;
    assign vga.Y           = yCnt;
    assign vga.HS          = hsReg;
    assign vga.VS          = vsReg;
    assign vga.VIDEO_ON    = videoReg;
    assign vga.PIXEL_TICK  = pixelTick;
    assign vga.FRAME_START = frameStartReg;
endmodule

// File: tb/tb_vga_sincronizacion.sv
// tb_vga_sincronizacion
// Drives two generators with shrunken geometries (DIV=4 and DIV=1) so that
// whole frames and a 257-frame wrap fit in a short run. Expected outputs come
// from a closed-form model: after n CLK edges since release, n/DIV pixels have
// elapsed, and X, Y, syncs and strobes follow from that pixel index.
module tb_vga_sincronizacion;
    // DUT A: DIV=4, 16x10 total
    localparam int unsigned A_DIV = 4;
    localparam int unsigned A_HV = 8, A_HF = 2, A_HS = 3, A_HB = 3;
    localparam int unsigned A_VV = 6, A_VF = 1, A_VS = 2, A_VB = 1;
    // DUT B: DIV=1, 7x6 total (42 CLK per frame)
    localparam int unsigned B_DIV = 1;
    localparam int unsigned B_HV = 4, B_HF = 1, B_HS = 1, B_HB = 1;
    localparam int unsigned B_VV = 3, B_VF = 1, B_VS = 1, B_VB = 1;

    logic CLK;
    logic rstNA;
    logic rstNB;
    int unsigned nA;
    int unsigned nB;
    int unsigned nChecks;
    int unsigned nFails;

    vga_sincronizacion_if busA ();
    vga_sincronizacion_if busB ();

    vga_sincronizacion #(
        .DIV(A_DIV), .H_VIS(A_HV), .H_FP(A_HF), .H_SYNC(A_HS), .H_BP(A_HB),
        .V_VIS(A_VV), .V_FP(A_VF), .V_SYNC(A_VS), .V_BP(A_VB)
    ) dutA (
        .CLK(CLK),
        .RESET_N(rstNA),
        .vga(busA)
    );

    vga_sincronizacion #(
        .DIV(B_DIV), .H_VIS(B_HV), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
        .V_VIS(B_VV), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB)
    ) dutB (
        .CLK(CLK),
        .RESET_N(rstNB),
        .vga(busB)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkVal(input string tag, input int unsigned got, input int unsigned exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void model(
        input  int unsigned n, input bit inRst, input int unsigned div,
        input  int unsigned hVis, input int unsigned hFp, input int unsigned hSync,
        input  int unsigned hBp, input int unsigned vVis, input int unsigned vFp,
        input  int unsigned vSync, input int unsigned vBp,
        output int unsigned x, output int unsigned y, output int unsigned hs,
        output int unsigned vs, output int unsigned vid, output int unsigned tick,
        output int unsigned fs, output int unsigned fc
    );
        int unsigned ht  = hVis + hFp + hSync + hBp;
        int unsigned vt  = vVis + vFp + vSync + vBp;
        int unsigned pix = n / div;
        int unsigned frm = ht * vt;
        x    = pix % ht;
        y    = (pix / ht) % vt;
        hs   = (x >= hVis + hFp && x < hVis + hFp + hSync) ? 0 : 1;
        vs   = (y >= vVis + vFp && y < vVis + vFp + vSync) ? 0 : 1;
        vid  = (x < hVis && y < vVis) ? 1 : 0;
        tick = (!inRst && (n % div) == div - 1) ? 1 : 0;
        fs   = (!inRst && pix > 0 && (pix % frm) == 0 && (n % div) == 0) ? 1 : 0;
        fc   = (pix / frm) % 256;
    endfunction

    task automatic checkA(input string pfx);
        int unsigned x, y, hs, vs, vid, tick, fs, fc;
        model(nA, !rstNA, A_DIV, A_HV, A_HF, A_HS, A_HB, A_VV, A_VF, A_VS, A_VB,
              x, y, hs, vs, vid, tick, fs, fc);
        checkVal({pfx, ".X"}, busA.X, x);
        checkVal({pfx, ".Y"}, busA.Y, y);
        checkVal({pfx, ".HS"}, busA.HS, hs);
        checkVal({pfx, ".VS"}, busA.VS, vs);
        checkVal({pfx, ".VIDEO_ON"}, busA.VIDEO_ON, vid);
        checkVal({pfx, ".PIXEL_TICK"}, busA.PIXEL_TICK, tick);
        checkVal({pfx, ".FRAME_START"}, busA.FRAME_START, fs);
`ifdef VGA_FRAME_COUNT_EN
        checkVal({pfx, ".FRAME_CNT"}, busA.FRAME_CNT, fc);
`endif
    endtask

    task automatic checkB(input string pfx);
        int unsigned x, y, hs, vs, vid, tick, fs, fc;
        model(nB, !rstNB, B_DIV, B_HV, B_HF, B_HS, B_HB, B_VV, B_VF, B_VS, B_VB,
              x, y, hs, vs, vid, tick, fs, fc);
        checkVal({pfx, ".X"}, busB.X, x);
        checkVal({pfx, ".Y"}, busB.Y, y);
        checkVal({pfx, ".HS"}, busB.HS, hs);
        checkVal({pfx, ".VS"}, busB.VS, vs);
        checkVal({pfx, ".VIDEO_ON"}, busB.VIDEO_ON, vid);
        checkVal({pfx, ".PIXEL_TICK"}, busB.PIXEL_TICK, tick);
        checkVal({pfx, ".FRAME_START"}, busB.FRAME_START, fs);
`ifdef VGA_FRAME_COUNT_EN
        checkVal({pfx, ".FRAME_CNT"}, busB.FRAME_CNT, fc);
`endif
    endtask

    // One CLK edge, then sample both DUTs on the falling edge.
    task automatic stepCycle();
        @(posedge CLK);
        if (rstNA) nA++;
        if (rstNB) nB++;
        @(negedge CLK);
        checkA("A");
        checkB("B");
    endtask

    initial begin
        int unsigned runA;
        nChecks = 0;
        nFails  = 0;
        nA      = 0;
        nB      = 0;
        rstNA   = 1'b0;
        rstNB   = 1'b0;

        // Reset held for 10 CLK: outputs sit at reset values.
        repeat (10) stepCycle();
        rstNA = 1'b1;
        rstNB = 1'b1;

        // Free run A for a random span of several frames, then hit reset mid-frame.
        runA = 3 * 640 + $urandom_range(0, 639);
        repeat (runA) stepCycle();

        rstNA = 1'b0;
        nA    = 0;
        #1;
        checkA("A.asyncReset");
        repeat (2 + $urandom_range(0, 3)) stepCycle();
        rstNA = 1'b1;

        // Continue until B has wrapped FRAME_CNT past 255 and A has run several frames.
        while (nB < 257 * 42 + 50) stepCycle();

        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
        $finish;
    end
endmodule
